// File: rtl/mig_if_pkg.sv
// Shared definitions for the MIG user-interface burst adapter.
//   MIG_CMD_RD / MIG_CMD_WR : app_cmd encodings
//   state_t                 : burst sequencer states
//   DW_DEF / ADDR_INC_DEF   : default data width and per-command address step
package mig_if_pkg;

  localparam logic [2:0] MIG_CMD_RD = 3'b001;
  localparam logic [2:0] MIG_CMD_WR = 3'b000;

  localparam int DW_DEF       = 128;
  localparam int ADDR_INC_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } state_t;

endpackage

// File: rtl/mig_rd_credit.sv
// Outstanding-read tracker for the MIG adapter.
// Counts read commands accepted by MIG that have not yet returned data, and
// grants a credit only while that count is below the free space in the read
// queue, because MIG cannot be stalled on read return.
// Ports:
//   mclk, mrst   clock, synchronous active-high reset
//   cmd_acc      a read command was accepted this cycle
//   data_ret     a read beat returned this cycle
//   rdq_free     free entries in the read queue
//   rd_inflight  outstanding read commands
//   credit_ok    another read command may be issued
module mig_rd_credit #(
  parameter int CW = 5
) (
  input  logic          mclk,
  input  logic          mrst,
  input  logic          cmd_acc,
  input  logic          data_ret,
  input  logic [CW-1:0] rdq_free,
  output logic [CW-1:0] rd_inflight,
  output logic          credit_ok
);

  always_ff @(posedge mclk) begin
    if (mrst) begin
      rd_inflight <= '0;
    end else if (cmd_acc && !data_ret) begin
      rd_inflight <= rd_inflight + 1'b1;
    end else if (!cmd_acc && data_ret) begin
      rd_inflight <= rd_inflight - 1'b1;
    end
  end

  assign credit_ok = (rd_inflight < rdq_free);

endmodule

// File: rtl/mig_if_burst.sv
// MIG app-interface burst adapter.
// Pops one request (address, length, direction) and expands it into req_len+1
// MIG commands at addresses stepping by ADDR_INC. Writes stream the same number
// of beats from the write-data queue; reads are throttled by read-queue credit.
// Ports:
//   mclk, mrst            clock, synchronous active-high reset
//   app_*                 MIG user interface (command, write data, read data)
//   req_*                 request queue read side (pop + head entry)
//   wdq_*                 write-data queue read side ({mask, data})
//   rdq_wen/rdq_wdata     read-queue write side (pass-through of MIG read data)
//   rdq_free              read-queue free entries
//   busy                  a burst is in progress
//
// state | meaning
// IDLE  | waiting for a request; pops it and loads the burst counters
// RD    | issuing read commands while credit allows
// WR    | issuing write commands and write beats independently
module mig_if_burst
  import mig_if_pkg::*;
#(
  parameter int DW       = DW_DEF,
  parameter int AW       = 28,
  parameter int LW       = 4,
  parameter int ADDR_INC = ADDR_INC_DEF,
  parameter int CW       = 5
) (
  input  logic                 mclk,
  input  logic                 mrst,
  output logic [AW-1:0]        app_addr,
  output logic [2:0]           app_cmd,
  output logic                 app_en,
  input  logic                 app_rdy,
  output logic [DW-1:0]        app_wdf_data,
  output logic [DW/8-1:0]      app_wdf_mask,
  output logic                 app_wdf_wren,
  output logic                 app_wdf_end,
  input  logic                 app_wdf_rdy,
  input  logic [DW-1:0]        app_rd_data,
  input  logic                 app_rd_data_end,
  input  logic                 app_rd_data_valid,
  output logic                 req_rnext,
  input  logic                 req_rqempty,
  input  logic [31:0]          req_qraddr,
  input  logic                 req_rd_bwt,
  input  logic [LW-1:0]        req_len,
  output logic                 wdq_rnext,
  input  logic                 wdq_rqempty,
  input  logic [DW+DW/8-1:0]   wdq_mask_rdata,
  output logic                 rdq_wen,
  output logic [DW-1:0]        rdq_wdata,
  input  logic [CW-1:0]        rdq_free,
  output logic                 busy
);

  // Counters need one extra bit to hold a full 2^LW burst.
  localparam int NW = LW + 1;
  localparam logic [AW-1:0] INC = AW'(ADDR_INC);

  state_t        state, state_nxt;
  logic [AW-1:0] addr_q, addr_nxt;
  logic [NW-1:0] cmd_left, cmd_nxt;
  logic [NW-1:0] dat_left, dat_nxt;
  logic [NW-1:0] req_n;
  logic          credit_ok;
  logic          rd_cmd_acc;
  logic [CW-1:0] rd_inflight;

  assign req_n = {1'b0, req_len} + 1'b1;

  always_comb begin
    state_nxt    = state;
    addr_nxt     = addr_q;
    cmd_nxt      = cmd_left;
    dat_nxt      = dat_left;
    app_en       = 1'b0;
    app_wdf_wren = 1'b0;
    req_rnext    = 1'b0;
    case (state)
      IDLE: begin
        req_rnext = ~req_rqempty & ~mrst;
        if (req_rnext) begin
          addr_nxt  = req_qraddr[AW-1:0];
          cmd_nxt   = req_n;
          dat_nxt   = req_rd_bwt ? '0 : req_n;
          state_nxt = req_rd_bwt ? RD : WR;
        end
      end
      RD: begin
        app_en = (cmd_left != '0) & credit_ok;
        if (app_en && app_rdy) begin
          addr_nxt = addr_q + INC;
          cmd_nxt  = cmd_left - 1'b1;
          if (cmd_left == NW'(1)) state_nxt = IDLE;
        end
      end
      WR: begin
        app_en       = (cmd_left != '0);
        app_wdf_wren = (dat_left != '0) & ~wdq_rqempty;
        if (app_en && app_rdy) begin
          addr_nxt = addr_q + INC;
          cmd_nxt  = cmd_left - 1'b1;
        end
        if (app_wdf_wren && app_wdf_rdy) dat_nxt = dat_left - 1'b1;
        // Either path may finish last; leave once both are exhausted.
        if (cmd_nxt == '0 && dat_nxt == '0) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge mclk) begin
    if (mrst) begin
      state    <= IDLE;
      addr_q   <= '0;
      cmd_left <= '0;
      dat_left <= '0;
    end else begin
      state    <= state_nxt;
      addr_q   <= addr_nxt;
      cmd_left <= cmd_nxt;
      dat_left <= dat_nxt;
    end
  end

  assign rd_cmd_acc = (state == RD) & app_en & app_rdy;

  mig_rd_credit #(.CW(CW)) u_rd_credit (
    .mclk       (mclk),
    .mrst       (mrst),
    .cmd_acc    (rd_cmd_acc),
    .data_ret   (app_rd_data_valid),
    .rdq_free   (rdq_free),
    .rd_inflight(rd_inflight),
    .credit_ok  (credit_ok)
  );

  assign app_addr     = addr_q;
  assign app_cmd      = (state == RD) ? MIG_CMD_RD : MIG_CMD_WR;
  assign app_wdf_data = wdq_mask_rdata[DW-1:0];
  assign app_wdf_mask = wdq_mask_rdata[DW+DW/8-1:DW];
  assign app_wdf_end  = app_wdf_wren;
  assign wdq_rnext    = app_wdf_wren & app_wdf_rdy;
  assign rdq_wen      = app_rd_data_valid;
  assign rdq_wdata    = app_rd_data;
  assign busy         = (state != IDLE);

  // Upper request-address bits and the MIG read-end strobe carry no information here.
  logic unused_ok;
  assign unused_ok = ^{app_rd_data_end, req_qraddr[31:AW], rd_inflight};

endmodule

// File: tb/tb_mig_if_burst.sv
module tb_mig_if_burst;
  localparam int DW  = 128;
  localparam int MW  = DW / 8;
  localparam int AW  = 28;
  localparam int LW  = 4;
  localparam int CW  = 5;
  localparam int INC = 8;

  typedef logic [DW+MW-1:0] v_t;
  typedef struct {logic rd; logic [AW-1:0] addr;} cmd_t;
  typedef struct {logic rd; logic [31:0] addr; logic [LW-1:0] len;} req_t;

  logic mclk = 1'b0;
  logic mrst;
  logic [AW-1:0] app_addr;
  logic [2:0] app_cmd;
  logic app_en, app_rdy;
  logic [DW-1:0] app_wdf_data;
  logic [MW-1:0] app_wdf_mask;
  logic app_wdf_wren, app_wdf_end, app_wdf_rdy;
  logic [DW-1:0] app_rd_data;
  logic app_rd_data_end, app_rd_data_valid;
  logic req_rnext, req_rqempty;
  logic [31:0] req_qraddr;
  logic req_rd_bwt;
  logic [LW-1:0] req_len;
  logic wdq_rnext, wdq_rqempty;
  logic [DW+MW-1:0] wdq_mask_rdata;
  logic rdq_wen;
  logic [DW-1:0] rdq_wdata;
  logic [CW-1:0] rdq_free;
  logic busy;

  always #5 mclk = ~mclk;

  mig_if_burst dut (
    .mclk(mclk), .mrst(mrst),
    .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en), .app_rdy(app_rdy),
    .app_wdf_data(app_wdf_data), .app_wdf_mask(app_wdf_mask),
    .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end), .app_wdf_rdy(app_wdf_rdy),
    .app_rd_data(app_rd_data), .app_rd_data_end(app_rd_data_end),
    .app_rd_data_valid(app_rd_data_valid),
    .req_rnext(req_rnext), .req_rqempty(req_rqempty), .req_qraddr(req_qraddr),
    .req_rd_bwt(req_rd_bwt), .req_len(req_len),
    .wdq_rnext(wdq_rnext), .wdq_rqempty(wdq_rqempty), .wdq_mask_rdata(wdq_mask_rdata),
    .rdq_wen(rdq_wen), .rdq_wdata(rdq_wdata), .rdq_free(rdq_free), .busy(busy)
  );

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: pending commands of the current burst, beats still owed,
  // reads awaiting data, and the request source.
  cmd_t exp_cmds[$];
  req_t req_q[$];
  int   rd_pend[$];
  int   beats_left = 0;
  int   inflight = 0;
  int   cyc = 0;

  logic [AW-1:0] acc_log[$];
  int   rnext_log[$];
  int   wdq_pops = 0;

  int rdy_pct = 100, wdf_pct = 100, wdq_pct = 100, free_knob = 16;
  int rd_allow = -1, lat_fix = 0;

  task automatic chk(input string name, input v_t act, input v_t exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_req(input logic rd, input logic [31:0] addr, input logic [LW-1:0] len);
    req_t r;
    r.rd = rd; r.addr = addr; r.len = len;
    req_q.push_back(r);
  endtask

  task automatic cycle();
    logic busy_e, cmd_e, en_e, wren_e, rnext_e;
    cmd_t c;
    req_t r;
    logic [159:0] tmp;
    @(negedge mclk);
    busy_e  = (exp_cmds.size() != 0) || (beats_left != 0);
    cmd_e   = (exp_cmds.size() != 0) && exp_cmds[0].rd;
    en_e    = (exp_cmds.size() != 0) && (!exp_cmds[0].rd || inflight < int'(rdq_free));
    wren_e  = (beats_left != 0) && !wdq_rqempty;
    rnext_e = !busy_e && !req_rqempty && !mrst;

    chk("busy", v_t'(busy), v_t'(busy_e));
    chk("app_en", v_t'(app_en), v_t'(en_e));
    chk("app_cmd", v_t'(app_cmd), v_t'({2'b00, cmd_e}));
    if (en_e) chk("app_addr", v_t'(app_addr), v_t'(exp_cmds[0].addr));
    chk("wren", v_t'(app_wdf_wren), v_t'(wren_e));
    chk("wdf_end", v_t'(app_wdf_end), v_t'(wren_e));
    if (wren_e) chk("wdf_data_mask", v_t'({app_wdf_mask, app_wdf_data}), wdq_mask_rdata);
    chk("wdq_rnext", v_t'(wdq_rnext), v_t'(wren_e && app_wdf_rdy));
    chk("req_rnext", v_t'(req_rnext), v_t'(rnext_e));
    chk("rdq_wen", v_t'(rdq_wen), v_t'(app_rd_data_valid));
    chk("rdq_wdata", v_t'(rdq_wdata), v_t'(app_rd_data));

    if (mrst) begin
      exp_cmds.delete(); rd_pend.delete();
      beats_left = 0; inflight = 0;
    end else begin
      if (app_rd_data_valid) inflight--;
      if (en_e && app_rdy) begin
        c = exp_cmds.pop_front();
        acc_log.push_back(c.addr);
        if (c.rd) begin
          inflight++;
          rd_pend.push_back(cyc + ((lat_fix > 0) ? lat_fix : int'($urandom_range(1, 5))));
        end
      end
      if (wren_e && app_wdf_rdy) begin
        beats_left--;
        wdq_pops++;
      end
      if (rnext_e) begin
        r = req_q.pop_front();
        rnext_log.push_back(cyc);
        for (int i = 0; i <= int'(r.len); i++) begin
          c.rd = r.rd;
          c.addr = AW'(r.addr + 32'(i * INC));
          exp_cmds.push_back(c);
        end
        if (!r.rd) beats_left = int'(r.len) + 1;
      end
    end

    @(posedge mclk);
    #1;
    cyc++;
    if (req_q.size() != 0) begin
      req_rqempty = 1'b0;
      req_qraddr  = req_q[0].addr;
      req_rd_bwt  = req_q[0].rd;
      req_len     = req_q[0].len;
    end else begin
      req_rqempty = 1'b1;
      req_qraddr  = $urandom;
      req_rd_bwt  = 1'($urandom_range(0, 1));
      req_len     = LW'($urandom_range(0, 15));
    end
    app_rdy     = (rdy_pct < 0) ? cyc[0] : (int'($urandom_range(0, 99)) < rdy_pct);
    app_wdf_rdy = int'($urandom_range(0, 99)) < wdf_pct;
    wdq_rqempty = !(int'($urandom_range(0, 99)) < wdq_pct);
    tmp = {$urandom, $urandom, $urandom, $urandom, $urandom};
    wdq_mask_rdata = tmp[DW+MW-1:0];
    app_rd_data = {$urandom, $urandom, $urandom, $urandom};
    app_rd_data_end = 1'($urandom_range(0, 1));
    if (rd_pend.size() != 0 && rd_pend[0] <= cyc && rd_allow != 0) begin
      app_rd_data_valid = 1'b1;
      void'(rd_pend.pop_front());
      if (rd_allow > 0) rd_allow--;
    end else begin
      app_rd_data_valid = 1'b0;
    end
    rdq_free = CW'(free_knob);
  endtask

  task automatic run_idle(input int max_cyc);
    int k;
    k = 0;
    while ((req_q.size() != 0 || exp_cmds.size() != 0 || beats_left != 0 ||
            rd_pend.size() != 0) && k < max_cyc) begin
      cycle();
      k++;
    end
    cycle();
    if (k >= max_cyc) chk("timeout_idle", v_t'(k), v_t'(0));
  endtask

  initial begin
    mrst = 1'b1;
    app_rdy = 1'b1; app_wdf_rdy = 1'b1; app_rd_data = '0; app_rd_data_end = 1'b0;
    app_rd_data_valid = 1'b0; req_rqempty = 1'b1; req_qraddr = '0; req_rd_bwt = 1'b0;
    req_len = '0; wdq_rqempty = 1'b0; wdq_mask_rdata = '0; rdq_free = CW'(16);

    repeat (3) cycle();
    mrst = 1'b0;
    chk("rst_busy", v_t'(busy), v_t'(0));
    chk("rst_app_en", v_t'(app_en), v_t'(0));
    chk("rst_wren", v_t'(app_wdf_wren), v_t'(0));
    chk("rst_rnext", v_t'(req_rnext), v_t'(0));

    // Single read at 0x100.
    lat_fix = 3; acc_log.delete();
    push_req(1'b1, 32'h100, 4'd0);
    run_idle(100);
    chk("t1_ncmd", v_t'(acc_log.size()), v_t'(1));
    if (acc_log.size() > 0) chk("t1_addr", v_t'(acc_log[0]), v_t'(28'h100));

    // Write burst wrapping the top of the address space, app_rdy toggling.
    lat_fix = 0; rdy_pct = -1; acc_log.delete(); wdq_pops = 0;
    push_req(1'b0, 32'h0FFF_FFF0, 4'd3);
    run_idle(200);
    chk("t2_ncmd", v_t'(acc_log.size()), v_t'(4));
    if (acc_log.size() == 4) begin
      chk("t2_a0", v_t'(acc_log[0]), v_t'(28'hFFF_FFF0));
      chk("t2_a1", v_t'(acc_log[1]), v_t'(28'hFFF_FFF8));
      chk("t2_a2", v_t'(acc_log[2]), v_t'(28'h000_0000));
      chk("t2_a3", v_t'(acc_log[3]), v_t'(28'h000_0008));
    end
    chk("t2_pops", v_t'(wdq_pops), v_t'(4));

    // Write data lagging the commands.
    rdy_pct = 100; wdq_pct = 0; acc_log.delete(); wdq_pops = 0;
    push_req(1'b0, 32'h2000, 4'd3);
    for (int k = 0; k < 50 && (req_q.size() != 0 || exp_cmds.size() != 0); k++) cycle();
    repeat (5) begin
      cycle();
      chk("t3_busy_hold", v_t'(busy), v_t'(1));
    end
    wdq_pct = 100;
    run_idle(100);
    chk("t3_ncmd", v_t'(acc_log.size()), v_t'(4));
    chk("t3_pops", v_t'(wdq_pops), v_t'(4));

    // Read credit limit: 2 free entries, data withheld.
    free_knob = 2; rd_allow = 0; lat_fix = 1; acc_log.delete();
    push_req(1'b1, 32'h4000, 4'd7);
    repeat (20) cycle();
    chk("t4_ncmd_2", v_t'(acc_log.size()), v_t'(2));
    chk("t4_en_low", v_t'(app_en), v_t'(0));
    rd_allow = 1;
    repeat (20) cycle();
    chk("t4_ncmd_3", v_t'(acc_log.size()), v_t'(3));
    chk("t4_busy", v_t'(busy), v_t'(1));
    mrst = 1'b1; cycle(); mrst = 1'b0;
    chk("t4_rst_busy", v_t'(busy), v_t'(0));
    chk("t4_rst_en", v_t'(app_en), v_t'(0));
    // After reset the in-flight count is clear, so 2 credits are available again.
    acc_log.delete(); rd_allow = 0;
    push_req(1'b1, 32'h5000, 4'd1);
    repeat (10) cycle();
    chk("t4_post_rst_ncmd", v_t'(acc_log.size()), v_t'(2));
    rd_allow = -1; lat_fix = 0; free_knob = 16;
    run_idle(100);

    // Reset in the middle of a write burst.
    wdq_pops = 0;
    push_req(1'b0, 32'h6000, 4'd3);
    for (int k = 0; k < 50 && wdq_pops < 2; k++) cycle();
    mrst = 1'b1; cycle(); mrst = 1'b0;
    chk("t5_pops", v_t'(wdq_pops), v_t'(2));
    chk("t5_busy", v_t'(busy), v_t'(0));
    chk("t5_en", v_t'(app_en), v_t'(0));
    chk("t5_wren", v_t'(app_wdf_wren), v_t'(0));
    acc_log.delete();
    push_req(1'b1, 32'h8000, 4'd0);
    run_idle(100);
    chk("t5_read_ncmd", v_t'(acc_log.size()), v_t'(1));
    if (acc_log.size() > 0) chk("t5_read_addr", v_t'(acc_log[0]), v_t'(28'h8000));

    // Back-to-back read then write.
    rnext_log.delete();
    push_req(1'b1, 32'h100, 4'd0);
    push_req(1'b0, 32'h200, 4'd1);
    run_idle(100);
    chk("t6_npops", v_t'(rnext_log.size()), v_t'(2));
    if (rnext_log.size() == 2) chk("t6_gap", v_t'(rnext_log[1] - rnext_log[0]), v_t'(2));

    // Randomised traffic.
    for (int it = 0; it < 40; it++) begin
      rdy_pct   = int'($urandom_range(30, 100));
      wdf_pct   = int'($urandom_range(30, 100));
      wdq_pct   = int'($urandom_range(30, 100));
      free_knob = int'($urandom_range(1, 8));
      for (int j = 0; j < int'($urandom_range(1, 3)); j++)
        push_req(1'($urandom_range(0, 1)), $urandom, LW'($urandom_range(0, 15)));
      run_idle(3000);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
